muldiv_ctrl: RTL and testbench

//  Sequencer for an iterative signed 32-bit multiply/divide unit and owner of the HI/LO registers.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_ctrl.sv | 136 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared types and constants for the iterative multiply/divide unit
//  Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_CALC = 2'd1;
    localparam logic [1:0] C_ST_SIGN = 2'd2;

    typedef enum logic [1:0] {
        IDLE = C_ST_IDLE,
        CALC = C_ST_CALC,
        SIGN = C_ST_SIGN
    } md_state_t;

    localparam logic [1:0] MVHL_NONE = 2'b00;
    localparam logic [1:0] MVHL_LO   = 2'b01;
    localparam logic [1:0] MVHL_HI   = 2'b10;

    // 2'b11 is illegal and behaves like no read at all
    function automatic logic is_hl_read(input logic [1:0] mvhl);
        return (mvhl == MVHL_LO) || (mvhl == MVHL_HI);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_if
//  Purpose  : EX-stage control/data bundle between decode and the mul/div unit
//  Revision : 1.0 - initial release
// ============================================================================
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_mult;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       mvhl;
    logic [WIDTH-1:0] hilo_out;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, is_mult, a, b, mvhl,
        input  hilo_out, busy, stall, done
    );

    modport slave (
        input  start, is_mult, a, b, mvhl,
        output hilo_out, busy, stall, done
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_step
//  Purpose  : One radix-2 iteration: shift-add multiply or restoring divide
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               i_is_mult,
    input  logic [2*WIDTH:0]   i_acc,
    input  logic [WIDTH:0]     i_opnd,
    output logic [2*WIDTH:0]   o_acc
);

    logic [WIDTH+1:0] w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_fit;

    // acc = {upper WIDTH+1 bits, lower WIDTH bits}; lower holds multiplier or dividend/quotient
    always_comb begin
        w_sum   = {1'b0, i_acc[2*WIDTH:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
        w_shift = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]};
        w_trial = {1'b0, w_shift} - {1'b0, i_opnd};
        w_fit   = ~w_trial[WIDTH+1];
        if (i_is_mult) begin
            o_acc = {w_sum, i_acc[WIDTH-1:1]};
        end else begin
            o_acc = {(w_fit ? w_trial[WIDTH:0] : w_shift), i_acc[WIDTH-2:0], w_fit};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : Sequencer for signed iterative MULT/DIV, owner of HI/LO, EX stall
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);

    localparam int                 C_CNT_W = $clog2(WIDTH);
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(WIDTH - 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt;
    logic [2*WIDTH:0]   r_acc;
    logic [2*WIDTH:0]   w_acc_step;
    logic [WIDTH:0]     r_opnd;
    logic [WIDTH:0]     w_abs_a;
    logic [WIDTH:0]     w_abs_b;
    logic               r_is_mult;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_load;
    logic               w_busy;

    // One extra bit so that |-2^(WIDTH-1)| is representable
    assign w_abs_a = bus.a[WIDTH-1] ? -{1'b1, bus.a} : {1'b0, bus.a};
    assign w_abs_b = bus.b[WIDTH-1] ? -{1'b1, bus.b} : {1'b0, bus.b};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .i_is_mult (r_is_mult),
        .i_acc     (r_acc),
        .i_opnd    (r_opnd),
        .o_acc     (w_acc_step)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = CALC;
                end
            end
            CALC:    if (r_cnt == C_LAST) w_state_nxt = SIGN;
            SIGN:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_acc     <= '0;
            r_opnd    <= '0;
            r_is_mult <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_done    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= (r_state == SIGN);
            if (w_load) begin
                r_acc     <= {(WIDTH+1)'(0), bus.is_mult ? w_abs_b[WIDTH-1:0] : w_abs_a[WIDTH-1:0]};
                r_opnd    <= bus.is_mult ? w_abs_a : w_abs_b;
                r_cnt     <= '0;
                r_is_mult <= bus.is_mult;
                r_neg_lo  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                r_neg_hi  <= bus.a[WIDTH-1];
            end else if (r_state == CALC) begin
                r_acc <= w_acc_step;
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == SIGN) begin
                r_hi <= w_hi_res;
                r_lo <= w_lo_res;
            end
        end
    end

    // Divide by zero leaves the dividend magnitude in the remainder, so HI = a falls out naturally
    always_comb begin
        w_prod = r_neg_lo ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
        if (r_is_mult) begin
            w_hi_res = w_prod[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod[WIDTH-1:0];
        end else begin
            w_hi_res = r_neg_hi ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            if (r_opnd == '0) begin
                w_lo_res = '1;
            end else begin
                w_lo_res = r_neg_lo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        case (bus.mvhl)
            MVHL_HI:            bus.hilo_out = r_hi;
            MVHL_LO, MVHL_NONE: bus.hilo_out = r_lo;
            default:            bus.hilo_out = r_lo;
        endcase
    end

    assign w_busy    = (r_state != IDLE);
    assign bus.busy  = w_busy;
    assign bus.stall = w_busy & (bus.start | is_hl_read(bus.mvhl));
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl against an arithmetic model
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [31:0] hi, output logic [31:0] lo);
        bus.mvhl = 2'b10;
        #1;
        hi = bus.hilo_out;
        bus.mvhl = 2'b01;
        #1;
        lo = bus.hilo_out;
        bus.mvhl = 2'b00;
    endtask

    // Reference: {HI, LO} from plain signed arithmetic
    function automatic logic [63:0] model(input bit m, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic [63:0]        r;
        sa = a;
        sb = b;
        if (m) begin
            r = longint'(sa) * longint'(sb);
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = {32'h0, 32'h8000_0000};
        end else begin
            r = {32'(sa % sb), 32'(sa / sb)};
        end
        return r;
    endfunction

    task automatic wait_idle(output int cyc, output bit saw_done, output bit stall_ok);
        cyc      = 0;
        saw_done = 1'b0;
        stall_ok = 1'b1;
        while (bus.busy === 1'b1 && cyc < 100) begin
            if (bus.done !== 1'b0) saw_done = 1'b1;
            if (bus.stall !== 1'b1) stall_ok = 1'b0;
            cyc++;
            tick;
        end
    endtask

    task automatic run_op(input bit m, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        bit          saw_done;
        bit          stall_ok;
        exp         = model(m, a, b);
        bus.start   = 1'b1;
        bus.is_mult = m;
        bus.a       = a;
        bus.b       = b;
        #1;
        chk($sformatf("%s stall_at_start", tag), 64'(bus.stall), 64'd0);
        tick;
        bus.start = 1'b0;
        wait_idle(cyc, saw_done, stall_ok);
        chk($sformatf("%s busy_cycles", tag), 64'(cyc), 64'(W + 1));
        chk($sformatf("%s early_done", tag), 64'(saw_done), 64'd0);
        chk($sformatf("%s done_pulse", tag), 64'(bus.done), 64'd1);
        read_hl(hi, lo);
        chk($sformatf("%s hi", tag), 64'(hi), 64'(exp[63:32]));
        chk($sformatf("%s lo", tag), 64'(lo), 64'(exp[31:0]));
        tick;
        chk($sformatf("%s done_clear", tag), 64'(bus.done), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] e1;
        logic [63:0] e2;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] ra;
        logic [31:0] rb;
        int          cyc;
        bit          saw_done;
        bit          stall_ok;
        bit          rm;

        bus.start   = 1'b0;
        bus.is_mult = 1'b0;
        bus.a       = '0;
        bus.b       = '0;
        bus.mvhl    = 2'b00;

        // reset state
        repeat (3) tick;
        chk("reset busy", 64'(bus.busy), 64'd0);
        chk("reset done", 64'(bus.done), 64'd0);
        read_hl(hi, lo);
        chk("reset hi", 64'(hi), 64'd0);
        chk("reset lo", 64'(lo), 64'd0);
        reset = 1'b1;
        tick;

        // directed arithmetic cases
        run_op(1'b1, 32'd7, 32'd6, "mult_7x6");
        run_op(1'b1, -32'sd3, 32'd5, "mult_m3x5");
        run_op(1'b0, 32'd100, 32'd7, "div_100_7");
        run_op(1'b0, -32'sd7, 32'd2, "div_m7_2");
        run_op(1'b0, 32'd5, 32'd0, "div_by_zero");
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
        run_op(1'b0, -32'sd9, 32'd0, "div_neg_by_zero");

        // MFHI issued three cycles into a MULT
        e1          = model(1'b1, 32'd123456, -32'sd789);
        bus.start   = 1'b1;
        bus.is_mult = 1'b1;
        bus.a       = 32'd123456;
        bus.b       = -32'sd789;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        bus.mvhl = 2'b10;
        #1;
        wait_idle(cyc, saw_done, stall_ok);
        chk("mfhi stall_while_busy", 64'(stall_ok), 64'd1);
        chk("mfhi done", 64'(bus.done), 64'd1);
        chk("mfhi stall_released", 64'(bus.stall), 64'd0);
        chk("mfhi value", 64'(bus.hilo_out), 64'(e1[63:32]));
        bus.mvhl = 2'b00;
        tick;

        // second MULT held behind a busy one, accepted on the done cycle
        e1          = model(1'b1, 32'd1000, 32'd3000);
        e2          = model(1'b1, -32'sd77, 32'd99);
        bus.start   = 1'b1;
        bus.is_mult = 1'b1;
        bus.a       = 32'd1000;
        bus.b       = 32'd3000;
        tick;
        bus.start = 1'b0;
        bus.mvhl  = 2'b11;
        #1;
        chk("illegal mvhl no_stall", 64'(bus.stall), 64'd0);
        bus.mvhl  = 2'b00;
        bus.start = 1'b1;
        bus.a     = -32'sd77;
        bus.b     = 32'd99;
        #1;
        wait_idle(cyc, saw_done, stall_ok);
        chk("held stall_while_busy", 64'(stall_ok), 64'd1);
        chk("held busy_cycles", 64'(cyc), 64'(W + 1));
        chk("held done", 64'(bus.done), 64'd1);
        chk("held stall_on_done", 64'(bus.stall), 64'd0);
        read_hl(hi, lo);
        chk("held first lo", 64'(lo), 64'(e1[31:0]));
        tick;
        bus.start = 1'b0;
        chk("held accepted busy", 64'(bus.busy), 64'd1);
        read_hl(hi, lo);
        chk("held no_bypass hi", 64'(hi), 64'(e1[63:32]));
        wait_idle(cyc, saw_done, stall_ok);
        chk("held second done", 64'(bus.done), 64'd1);
        read_hl(hi, lo);
        chk("held second hi", 64'(hi), 64'(e2[63:32]));
        chk("held second lo", 64'(lo), 64'(e2[31:0]));
        tick;

        // reset in the middle of a DIV
        bus.start   = 1'b1;
        bus.is_mult = 1'b0;
        bus.a       = 32'd1234567;
        bus.b       = 32'd89;
        tick;
        bus.start = 1'b0;
        repeat (8) tick;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("midreset busy", 64'(bus.busy), 64'd0);
        chk("midreset done", 64'(bus.done), 64'd0);
        read_hl(hi, lo);
        chk("midreset hi", 64'(hi), 64'd0);
        chk("midreset lo", 64'(lo), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
            tick;
        end
        chk("midreset quiet", 64'(saw_done), 64'd0);
        run_op(1'b1, 32'd2, 32'd3, "after_reset_2x3");

        // randomized operations
        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom_range(0, 1));
            ra = (($urandom_range(0, 2)) == 0) ? 32'($urandom_range(0, 200)) - 32'd100 : 32'($urandom);
            rb = (($urandom_range(0, 2)) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
            run_op(rm, ra, rb, $sformatf("rand%0d_%s_%0h_%0h", i, rm ? "mult" : "div", ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
